cga_text_fetch: RTL and testbench
=================================

CGA_TEXT_FETCH -- requirements
Module: cga_text_fetch

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port pix_ce, input, 1, pixel clock enable; one pixel per asserted cycle; at most every 2nd clk.
REQ-004 SHALL have ports disp_en (in, 1, active display), line_start (in, 1, one-clk pulse per scanline) and frame_start (in, 1, one-clk pulse per frame).
REQ-005 SHALL have ports start_addr (in, 13, byte address of top-left char) and cursor_addr (in, 13, cursor byte address).
REQ-006 SHALL have ports cursor_start and cursor_end (in, 3 each, cursor scanline range) and blink_en (in, 1, attr bit7 = blink, else bright background).
REQ-007 SHALL have ports vram_en (out, 1), vram_addr (out, 13) and vram_dout (in, 8), driving a read-only VRAM port with 1-clk read latency.
REQ-008 SHALL have ports pix_out (out, 4, IRGB) and pix_valid (out, 1).

Function
REQ-009 SHALL run a fetch FSM IDLE -> REQ_CHAR -> REQ_ATTR -> REQ_FONT -> LOAD -> WAIT, one clk per state except WAIT.
REQ-010 SHALL assert vram_en for exactly one clk in REQ_CHAR (even addr) and one in REQ_ATTR (addr+1), and SHALL capture data one clk later.
REQ-011 SHALL address the font ROM as {char,scanline[2:0]} with 1-clk latency, then latch glyph row, attr and cursor flag into a prefetch buffer in LOAD.
REQ-012 SHALL stay in WAIT until the shift register takes the buffer, then SHALL go to REQ_CHAR with vram_addr+2.
REQ-013 SHALL shift the 8-bit glyph MSB-first, one bit per pix_ce while disp_en=1, and SHALL reload from the buffer after bit 0.
REQ-014 SHALL output pix_out = attr[3:0] for a 1-bit and the background for a 0-bit; background = attr[6:4] when blink_en=1, else attr[7:4].
REQ-015 SHALL output background for all 8 pixels when blink_en=1, attr[7]=1 and frame_cnt[4]=1.
REQ-016 SHALL output foreground for all pixels of a cell when addr==cursor_addr, cursor_start<=scanline<=cursor_end and frame_cnt[3]=1.
REQ-017 SHALL drive pix_out=0 and pix_valid=0 while disp_en=0; otherwise pix_valid=disp_en registered with pix_out.
REQ-018 SHALL have a pixel latency of one clk from the pix_ce edge to pix_out.
REQ-019 SHALL, on line_start, abort any fetch, load addr=row_base, enter REQ_CHAR and prime the shift register so that the first pixel is ready; line_start comes >=12 clk before disp_en.
REQ-020 SHALL keep scanline 0..7 and increment it on each line_start after the first of a frame; after 7 it SHALL wrap to 0 with row_base += 160.
REQ-021 SHALL, on frame_start, set scanline=0, row_base=start_addr and frame_cnt += 1 (5-bit, wraps).
REQ-022 SHALL give frame_start priority when it coincides with line_start; the line then fetches from start_addr.
REQ-023 SHALL compute all addresses modulo 8192 (13-bit wrap, no saturation).

Reset
REQ-024 SHALL, while reset_n=0, force FSM=IDLE, vram_en=0, vram_addr=0, pix_out=0, pix_valid=0, scanline=0, row_base=0, frame_cnt=0 and the buffers to 0.
REQ-025 SHALL drop outputs to 0 immediately on a mid-line reset and SHALL emit nothing until the next line_start after release.

Configuration
REQ-026 SHALL, when CGA_CURSOR_EN is defined, implement REQ-016.
REQ-027 SHALL, when CGA_CURSOR_EN is undefined, ignore cursor_addr, cursor_start and cursor_end and never force cursor pixels.

Structure
REQ-028 SHALL take the FSM state enum, CHAR_W=8, CHAR_H=8, ROW_BYTES=160 and VRAM_AW=13 from a shared package cga_pkg.
REQ-029 SHALL put the 2048x8 font in sub-module cga_font_rom (registered output, hex-initialised).

Verification
REQ-030 SHALL check: VRAM[0]=0x41, [1]=0x1F, start_addr=0, scanline 0 -> pix_out is font('A',0) bits with fg 0xF, bg 0x1.
REQ-031 SHALL check: 8 line_starts -> row_base=160 and the first vram_addr of the 9th line is 160.
REQ-032 SHALL check: start_addr=8190 -> fetch addresses 8190, 8191, 0, 1.
REQ-033 SHALL check: attr=0x8F, blink_en=1, frame_cnt=16 -> all pixels 0x0; with blink_en=0 -> bg 0x8.
REQ-034 SHALL check: cursor_addr=2, cursor 6..7, frame_cnt=8, scanline 6 -> cell 1 is all fg; without CGA_CURSOR_EN -> the glyph is normal.
REQ-035 SHALL check: reset_n low at pixel 3 -> pix_out=0 that cycle, and no pix_valid until the next line_start.

Source files
------------

// File: rtl/cga_pkg.sv
// Shared types and geometry for the CGA text-mode fetch path.
package cga_pkg;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 8;
  localparam int ROW_BYTES = 160;
  localparam int VRAM_AW   = 13;
  localparam int FONT_AW   = 11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ_CHAR, ST_REQ_ATTR, ST_REQ_FONT, ST_LOAD, ST_WAIT
  } fetch_state_t;

  // One character cell: glyph row, attribute byte, cursor-hit flag.
  typedef struct packed {
    logic [7:0] glyph;
    logic [7:0] attr;
    logic       cur;
  } cell_t;
endpackage

// File: rtl/cga_text_fetch_if.sv
// VRAM read port and pixel output stream of the text fetcher.
interface cga_text_fetch_if;
  import cga_pkg::*;
  logic               vram_en;
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_dout;
  logic [3:0]         pix_out;
  logic               pix_valid;

  modport master (output vram_en, vram_addr, pix_out, pix_valid, input vram_dout);
  modport slave  (input vram_en, vram_addr, pix_out, pix_valid, output vram_dout);
endinterface

// File: rtl/cga_font_rom.sv
// 2048x8 character ROM addressed {char, row}, registered output.
// Glyph rows are hex constants, eight rows packed MSB-first per code;
// codes not listed read as blank.
module cga_font_rom
  import cga_pkg::*;
(
  input  logic               clk,
  input  logic [FONT_AW-1:0] addr,
  output logic [7:0]         data
);
  function automatic logic [7:0] glyph_row(input logic [FONT_AW-1:0] a);
    logic [63:0] g;
    case (a[FONT_AW-1:3])
      8'h41:   g = 64'h3078CCCCFCCCCC00;  // 'A'
      8'h42:   g = 64'hFC66667C6666FC00;  // 'B'
      default: g = 64'h0;
    endcase
    return g[8*(7-int'(a[2:0])) +: 8];
  endfunction

  // Synchronous read: data is valid one clk after addr.
  always_ff @(posedge clk)
    data <= glyph_row(addr);
endmodule

// File: rtl/cga_text_fetch.sv
// CGA text-mode character fetcher and pixel shifter.
// Define CGA_CURSOR_EN to enable the blinking block cursor.
module cga_text_fetch
  import cga_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_ce,
  input  logic               disp_en,
  input  logic               line_start,
  input  logic               frame_start,
  input  logic [VRAM_AW-1:0] start_addr,
  input  logic [VRAM_AW-1:0] cursor_addr,
  input  logic [2:0]         cursor_start,
  input  logic [2:0]         cursor_end,
  input  logic               blink_en,
  cga_text_fetch_if.master   bus
);
  fetch_state_t       state, state_nxt;
  logic [VRAM_AW-1:0] addr, row_base, base_nxt, vram_addr;
  logic [2:0]         scanline, scan_nxt;
  logic [4:0]         frame_cnt;
  logic               first_line, line_active, vram_en;
  logic [7:0]         char_q, attr_q, font_q;
  cell_t              buf_q, sh_q;
  logic               buf_full, shift, take, cur_hit;
  logic [3:0]         sh_cnt, fg, bg, pix, pix_out;
  logic               hide, pix_valid;

  cga_font_rom u_font (.clk(clk), .addr({char_q, scanline}), .data(font_q));

`ifdef CGA_CURSOR_EN
  assign cur_hit = (addr == cursor_addr) && (scanline >= cursor_start) &&
                   (scanline <= cursor_end);
`else
  // Cursor inputs are tied off; the flag is never set.
  assign cur_hit = 1'b0 & (^{cursor_addr, cursor_start, cursor_end});
`endif

  // Next scanline / row base; frame_start wins over line_start.
  always_comb begin
    base_nxt = row_base;
    scan_nxt = scanline;
    if (frame_start) begin
      base_nxt = start_addr;
      scan_nxt = '0;
    end else if (line_start && !first_line) begin
      scan_nxt = scanline + 3'd1;
      if (scanline == 3'(CHAR_H-1)) base_nxt = row_base + VRAM_AW'(ROW_BYTES);
    end
  end

  // Frame/line bookkeeping; the first line_start of a frame keeps scanline 0.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      row_base    <= '0;
      scanline    <= '0;
      frame_cnt   <= '0;
      first_line  <= 1'b1;
      line_active <= 1'b0;
    end else begin
      row_base <= base_nxt;
      scanline <= scan_nxt;
      if (frame_start) frame_cnt <= frame_cnt + 5'd1;
      if (line_start) begin
        first_line  <= 1'b0;
        line_active <= 1'b1;
      end else if (frame_start) first_line <= 1'b1;
    end

  // Fetch FSM next state and VRAM request; line_start restarts the fetch.
  always_comb begin
    state_nxt = state;
    vram_en   = 1'b0;
    vram_addr = addr;
    case (state)
      ST_IDLE:     state_nxt = ST_IDLE;
      ST_REQ_CHAR: begin vram_en = 1'b1; state_nxt = ST_REQ_ATTR; end
      ST_REQ_ATTR: begin
        vram_en   = 1'b1;
        vram_addr = addr + VRAM_AW'(1);
        state_nxt = ST_REQ_FONT;
      end
      ST_REQ_FONT: state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = ST_WAIT;
      ST_WAIT:     if (take) state_nxt = ST_REQ_CHAR;
      default:     state_nxt = ST_IDLE;
    endcase
    if (line_start) state_nxt = ST_REQ_CHAR;
  end

  // State register, cell address, VRAM data capture.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= ST_IDLE;
      addr   <= '0;
      char_q <= '0;
      attr_q <= '0;
    end else begin
      state <= state_nxt;
      if (line_start) addr <= base_nxt;
      else if (state == ST_WAIT && take) addr <= addr + VRAM_AW'(2);
      if (state == ST_REQ_ATTR) char_q <= bus.vram_dout;
      if (state == ST_REQ_FONT) attr_q <= bus.vram_dout;
    end

  // Shifter takes the buffer when empty or as its last bit goes out.
  assign shift = pix_ce && disp_en && line_active;
  assign take  = buf_full && (sh_cnt == 4'd0 || (shift && sh_cnt == 4'd1));

  // Prefetch buffer and MSB-first glyph shifter.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      sh_q     <= '0;
      sh_cnt   <= '0;
    end else if (line_start) begin
      buf_full <= 1'b0;
      sh_cnt   <= '0;
    end else begin
      if (state == ST_LOAD) begin
        buf_q    <= '{glyph: font_q, attr: attr_q, cur: cur_hit};
        buf_full <= 1'b1;
      end else if (take) buf_full <= 1'b0;
      if (take) begin
        sh_q   <= buf_q;
        sh_cnt <= 4'(CHAR_W);
      end else if (shift && sh_cnt != 4'd0) begin
        sh_q.glyph <= {sh_q.glyph[6:0], 1'b0};
        sh_cnt     <= sh_cnt - 4'd1;
      end
    end

  // Colour of the current pixel: blink hides, cursor forces foreground.
  always_comb begin
    fg   = sh_q.attr[3:0];
    bg   = blink_en ? {1'b0, sh_q.attr[6:4]} : sh_q.attr[7:4];
    hide = blink_en && sh_q.attr[7] && frame_cnt[4];
    pix  = (sh_q.glyph[7] && !hide) ? fg : bg;
    if (sh_q.cur && frame_cnt[3]) pix = fg;
  end

  // Registered pixel output, blanked outside active display.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= disp_en && line_active;
      if (!disp_en) pix_out <= '0;
      else if (shift) pix_out <= pix;
    end

  assign bus.vram_en   = vram_en;
  assign bus.vram_addr = vram_addr;
  assign bus.pix_out   = pix_out;
  assign bus.pix_valid = pix_valid;
endmodule

// File: tb/tb_cga_text_fetch.sv
// Scoreboard bench for cga_text_fetch: stimulus pushes expected pixels and
// fetch addresses; monitors pop and compare as the DUT produces them.
module tb_cga_text_fetch;
  import cga_pkg::*;

  logic        clk = 0, reset_n = 0, pix_ce = 0, disp_en = 0;
  logic        line_start = 0, frame_start = 0, blink_en = 1;
  logic [12:0] start_addr = 0, cursor_addr = 13'd2;
  logic [2:0]  cursor_start = 3'd6, cursor_end = 3'd7;
  logic [7:0]  mem [8192];
  logic [3:0]  exp_pix [$];
  logic [12:0] exp_addr [$];
  logic        ce_d = 0;
  int          total = 0, bad = 0;

  cga_text_fetch_if bus();

  cga_text_fetch dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .disp_en(disp_en),
    .line_start(line_start), .frame_start(frame_start),
    .start_addr(start_addr), .cursor_addr(cursor_addr),
    .cursor_start(cursor_start), .cursor_end(cursor_end),
    .blink_en(blink_en), .bus(bus)
  );

  always #5 clk = ~clk;

  // VRAM model, one clk read latency.
  always @(posedge clk) if (bus.vram_en) bus.vram_dout <= mem[bus.vram_addr];

  always @(posedge clk) ce_d <= pix_ce;

  // Pixel monitor: one comparison per pixel strobe.
  always @(negedge clk)
    if (bus.pix_valid && ce_d) begin
      total++;
      if (exp_pix.size() == 0) begin
        bad++;
        $display("FAIL pix_extra got=%h exp=none", bus.pix_out);
      end else begin
        logic [3:0] e;
        e = exp_pix.pop_front();
        if (bus.pix_out !== e) begin
          bad++;
          $display("FAIL pix got=%h exp=%h", bus.pix_out, e);
        end
      end
    end

  // Address monitor: compares fetches only while expectations are queued.
  always @(negedge clk)
    if (bus.vram_en && exp_addr.size() != 0) begin
      logic [12:0] a;
      a = exp_addr.pop_front();
      total++;
      if (bus.vram_addr !== a) begin
        bad++;
        $display("FAIL vram_addr got=%0d exp=%0d", bus.vram_addr, a);
      end
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Eight pixels, first pixel in the top nibble.
  task automatic push8(input logic [31:0] v);
    for (int i = 0; i < 8; i++) exp_pix.push_back(v[31-4*i -: 4]);
  endtask

  task automatic start_line(input bit fs);
    @(negedge clk); line_start = 1; frame_start = fs;
    @(negedge clk); line_start = 0; frame_start = 0;
    repeat (14) @(negedge clk);
  endtask

  task automatic pixels(input int n);
    disp_en = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); pix_ce = 1;
      @(negedge clk); pix_ce = 0;
    end
    @(negedge clk); disp_en = 0;
    repeat (12) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_start = 1;
      @(negedge clk); frame_start = 0;
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[0] = 8'h41;    mem[1] = 8'h1F;
    mem[2] = 8'h42;    mem[3] = 8'h8F;
    mem[160] = 8'h41;  mem[161] = 8'h4E;
    mem[8190] = 8'h42; mem[8191] = 8'h2A;

    repeat (3) @(negedge clk);
    check("rst_vram_en", 32'(bus.vram_en), 0);
    check("rst_vram_addr", 32'(bus.vram_addr), 0);
    check("rst_pix_out", 32'(bus.pix_out), 0);
    check("rst_pix_valid", 32'(bus.pix_valid), 0);
    reset_n = 1;

    // Frame 1, scanline 0: 'A' fg F bg 1, then 'B' attr 8F (bg 0).
    exp_addr.push_back(0); exp_addr.push_back(1);
    exp_addr.push_back(2); exp_addr.push_back(3);
    push8(32'h11FF1111); push8(32'hFFFFFF00);
    start_line(1); pixels(16);

    // Scanline 1, bright background: attr 8F gives bg 8.
    blink_en = 0;
    push8(32'h1FFFF111); push8(32'h8FF88FF8);
    start_line(0); pixels(16);

    // Frame 8, scanline 6: cursor on cell at address 2.
    blink_en = 1;
    frames(6);
    start_line(1);
    repeat (5) start_line(0);
    push8(32'hFF11FF11);
`ifdef CGA_CURSOR_EN
    push8(32'hFFFFFFFF);
`else
    push8(32'hFFFFFF00);
`endif
    start_line(0); pixels(16);

    // Scanline 7, then the 9th line starts at row_base 160.
    start_line(0);
    exp_addr.push_back(160); exp_addr.push_back(161);
    push8(32'h44EE4444);
    start_line(0); pixels(8);

    // Frame 16: blinking attr 8F hidden; bright-bg mode shows bg 8.
    frames(7);
    push8(32'h11FF1111); push8(32'h00000000);
    start_line(1); pixels(16);
    blink_en = 0;
    push8(32'h1FFFF111); push8(32'h8FF88FF8);
    start_line(0); pixels(16);

    // Address wrap from 8190.
    blink_en = 1;
    start_addr = 13'd8190;
    exp_addr.push_back(8190); exp_addr.push_back(8191);
    exp_addr.push_back(0);    exp_addr.push_back(1);
    push8(32'hAAAAAA22); push8(32'h11FF1111);
    start_line(1); pixels(16);

    // Mid-line reset at pixel 3.
    start_addr = 0;
    exp_pix.push_back(4'h1); exp_pix.push_back(4'h1); exp_pix.push_back(4'hF);
    start_line(1);
    disp_en = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); pix_ce = 1;
      @(negedge clk); pix_ce = 0;
    end
    @(negedge clk); pix_ce = 1;
    @(posedge clk); #1 reset_n = 0;
    #1;
    check("rst_mid_pix_out", 32'(bus.pix_out), 0);
    check("rst_mid_pix_valid", 32'(bus.pix_valid), 0);
    @(negedge clk); pix_ce = 0;
    repeat (2) @(negedge clk);
    check("rst_mid_vram_en", 32'(bus.vram_en), 0);
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pix_valid) seen = 1;
      pix_ce = ~pix_ce;
    end
    pix_ce = 0;
    @(negedge clk); disp_en = 0;
    check("silent_after_reset", 32'(seen), 0);

    // Output resumes on the next line_start, scanline 0, row 0.
    push8(32'h11FF1111);
    start_line(0); pixels(8);

    check("pix_queue_empty", exp_pix.size(), 0);
    check("addr_queue_empty", exp_addr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
